// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side memory loader.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rxState_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LANE_COUNT = 4;
  localparam int unsigned WORD_W     = LANE_COUNT * BYTE_W;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, start/data/stop FSM and bit timer.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadEn,
  input  logic              rxd,
  output logic [BYTE_W-1:0] rxByte,
  output logic              byteValid,
  output logic              frameErr
);

  localparam int unsigned TICK_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0]    HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0]    FULL_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

  rxState_e              state, stateNext;
  logic [TICK_W-1:0]     tick, tickNext;
  logic [BIT_IDX_W-1:0]  bitIdx, bitIdxNext;
  logic [BYTE_W-1:0]     shiftReg, shiftNext;
  logic                  byteValidNext, frameErrNext;
  logic                  rxdMeta, rxdS;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxdMeta <= 1'b1;
      rxdS    <= 1'b1;
    end else begin
      rxdMeta <= rxd;
      rxdS    <= rxdMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tick      <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state     <= stateNext;
      tick      <= tickNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      byteValid <= byteValidNext;
      frameErr  <= frameErrNext;
    end
  end

  always_comb begin
    stateNext     = state;
    tickNext      = tick;
    bitIdxNext    = bitIdx;
    shiftNext     = shiftReg;
    byteValidNext = 1'b0;
    frameErrNext  = 1'b0;

    // Dropping loadEn abandons any frame in flight, even on its stop sample
    if (!loadEn) begin
      stateNext  = IDLE;
      tickNext   = '0;
      bitIdxNext = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxdS) begin
            stateNext = START;
            tickNext  = '0;
          end
        end
        START: begin
          if (tick == HALF_TICK) begin
            tickNext = '0;
            if (rxdS) begin
              stateNext = IDLE;
            end else begin
              stateNext  = DATA;
              bitIdxNext = '0;
            end
          end else begin
            tickNext = tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == FULL_TICK) begin
            tickNext          = '0;
            shiftNext[bitIdx] = rxdS;
            if (bitIdx == LAST_BIT) begin
              stateNext = STOP;
            end else begin
              bitIdxNext = bitIdx + 1'b1;
            end
          end else begin
            tickNext = tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == FULL_TICK) begin
            tickNext  = '0;
            stateNext = IDLE;
            if (rxdS) begin
              byteValidNext = 1'b1;
            end else begin
              frameErrNext = 1'b1;
            end
          end else begin
            tickNext = tick + 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign rxByte = shiftReg;

endmodule

// File: rtl/uart_mem_loader.sv
// Packs received UART bytes little-endian into words and writes them to data memory.
module uart_mem_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loadEn,
  input  logic                  rxd,
  output logic                  writeEn,
  output logic [31:0]           address,
  output logic [WORD_W-1:0]     dataIn,
  output logic                  byteValid,
  output logic                  frameErr,
  output logic [ADDR_WIDTH-1:0] wordCount
);

  localparam int unsigned       LANE_W    = $clog2(LANE_COUNT);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANE_COUNT - 1);

  logic [BYTE_W-1:0]     rxByte;
  logic                  rxValid;
  logic                  rxErr;
  logic [LANE_W-1:0]     lane;
  logic [WORD_W-1:0]     wordBuf;
  logic [WORD_W-1:0]     wordNext;
  logic [ADDR_WIDTH-1:0] addrCnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) rxByteInst (
    .clk      (clk),
    .rst      (rst),
    .loadEn   (loadEn),
    .rxd      (rxd),
    .rxByte   (rxByte),
    .byteValid(rxValid),
    .frameErr (rxErr)
  );

  // Current word with the incoming byte merged into its lane
  always_comb begin
    wordNext = wordBuf;
    wordNext[{lane, 3'b000} +: BYTE_W] = rxByte;
  end

  // Lane packing, write strobe and address/word counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane      <= '0;
      wordBuf   <= '0;
      addrCnt   <= '0;
      writeEn   <= 1'b0;
      address   <= '0;
      dataIn    <= '0;
      wordCount <= '0;
    end else begin
      writeEn <= 1'b0;
      if (writeEn) begin
        addrCnt   <= addrCnt + 1'b1;
        wordCount <= wordCount + 1'b1;
        lane      <= '0;
      end
      if (!loadEn) begin
        lane <= '0;
      end else if (rxValid) begin
        wordBuf <= wordNext;
        if (lane == LAST_LANE) begin
          writeEn <= 1'b1;
          dataIn  <= wordNext;
          address <= 32'(addrCnt);
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

  assign byteValid = rxValid;
  assign frameErr  = rxErr;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: serial driver, word-packing model, output monitor.
module tb_uart_mem_loader;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          loadEn = 1'b0;
  logic          rxd    = 1'b1;
  logic          writeEn;
  logic [31:0]   address;
  logic [31:0]   dataIn;
  logic          byteValid;
  logic          frameErr;
  logic [AW-1:0] wordCount;

  uart_mem_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .loadEn   (loadEn),
    .rxd      (rxd),
    .writeEn  (writeEn),
    .address  (address),
    .dataIn   (dataIn),
    .byteValid(byteValid),
    .frameErr (frameErr),
    .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wc;
  } expWrite_t;

  expWrite_t   expWrites[$];
  logic [7:0]  laneQ[$];
  int          pendingGood = 0;
  int          pendingErr  = 0;
  int          modelAddr   = 0;
  int          modelCount  = 0;
  int          vectors     = 0;
  int          miscompares = 0;

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: four good bytes form one little-endian word at the next address
  function void modelGood(logic [7:0] b);
    expWrite_t w;
    pendingGood++;
    laneQ.push_back(b);
    if (laneQ.size() == 4) begin
      w.data = {laneQ[3], laneQ[2], laneQ[1], laneQ[0]};
      w.addr = 32'(modelAddr);
      w.wc   = 32'(modelCount);
      expWrites.push_back(w);
      modelAddr  = (modelAddr + 1) % (1 << AW);
      modelCount = (modelCount + 1) % (1 << AW);
      laneQ.delete();
    end
  endfunction

  task automatic driveBit(logic v);
    repeat (CPB) begin
      @(negedge clk);
      rxd = v;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  task automatic sendFrame(logic [7:0] b, logic stopBit, int gap);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stopBit);
    if (stopBit) modelGood(b);
    else pendingErr++;
    idle(gap);
  endtask

  task automatic dropLoad();
    idle(4);
    @(negedge clk);
    loadEn = 1'b0;
    @(negedge clk);
    loadEn = 1'b1;
    laneQ.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("rst writeEn", 32'(writeEn), 32'd0);
    check("rst address", address, 32'd0);
    check("rst dataIn", dataIn, 32'd0);
    check("rst byteValid", 32'(byteValid), 32'd0);
    check("rst frameErr", 32'(frameErr), 32'd0);
    check("rst wordCount", 32'(wordCount), 32'd0);
    rst = 1'b1;
    laneQ.delete();
    modelAddr  = 0;
    modelCount = 0;
  endtask

  // Monitor: every DUT pulse or strobe must match a pending expectation
  always @(negedge clk) begin
    if (rst) begin
      if (byteValid) begin
        check("byteValid expected", 32'(pendingGood > 0), 32'd1);
        check("byteValid/frameErr exclusive", 32'(frameErr), 32'd0);
        if (pendingGood > 0) pendingGood--;
      end
      if (frameErr) begin
        check("frameErr expected", 32'(pendingErr > 0), 32'd1);
        if (pendingErr > 0) pendingErr--;
      end
      if (writeEn) begin
        if (expWrites.size() == 0) begin
          check("unexpected writeEn", 32'd1, 32'd0);
        end else begin
          expWrite_t w;
          w = expWrites.pop_front();
          check("write address", address, w.addr);
          check("write dataIn", dataIn, w.data);
          check("wordCount at strobe", 32'(wordCount), w.wc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       good;
    int         gap;

    doReset();
    loadEn = 1'b1;
    idle(4);

    // First word: AA 0F F0 AE -> 0xAEF00FAA at address 0
    sendFrame(8'hAA, 1'b1, 0);
    sendFrame(8'h0F, 1'b1, 0);
    sendFrame(8'hF0, 1'b1, 0);
    sendFrame(8'hAE, 1'b1, 10);
    check("wordCount after first word", 32'(wordCount), 32'd1);
    check("first word address", address, 32'd0);
    check("first word dataIn", dataIn, 32'hAEF00FAA);

    // Four more words with zero inter-frame gap; address wraps to 0
    for (int i = 0; i < 16; i++) sendFrame(8'($urandom), 1'b1, 0);
    idle(10);
    check("wordCount after wrap", 32'(wordCount), 32'd1);
    check("address after wrap", address, 32'd0);

    // Two-cycle glitch is a false start, then a clean 0x55
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b0;
    idle(12);
    sendFrame(8'h55, 1'b1, 10);
    check("pending bytes after 0x55", 32'(pendingGood), 32'd0);
    dropLoad();

    // Bad stop bit leaves the lane where it was
    sendFrame(8'h12, 1'b0, 8);
    check("pending frameErr after bad stop", 32'(pendingErr), 32'd0);
    sendFrame(8'h34, 1'b1, 0);
    sendFrame(8'h56, 1'b1, 0);
    sendFrame(8'h78, 1'b1, 0);
    sendFrame(8'h9A, 1'b1, 10);
    check("dataIn after bad byte", dataIn, 32'h9A785634);

    // Partial word discarded by loadEn drop; address counter preserved
    sendFrame(8'($urandom), 1'b1, 0);
    sendFrame(8'($urandom), 1'b1, 2);
    dropLoad();
    for (int i = 1; i <= 4; i++) sendFrame(8'(i), 1'b1, 0);
    idle(10);
    check("dataIn after loadEn drop", dataIn, 32'h04030201);
    check("wordCount after loadEn drop", 32'(wordCount), 32'(modelCount));

    // Randomized traffic: random bytes, gaps, bad stops and load drops
    for (int i = 0; i < 40; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 9) != 0);
      gap  = good ? int'($urandom_range(0, 3)) : 8;
      sendFrame(b, good, gap);
      if ($urandom_range(0, 7) == 0) dropLoad();
    end
    idle(12);
    check("wordCount after random", 32'(wordCount), 32'(modelCount));

    // Reset in the middle of the third byte's data bits
    sendFrame(8'hC3, 1'b1, 0);
    sendFrame(8'h3C, 1'b1, 0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    doReset();
    idle(20);
    check("no strobe after mid-frame reset", 32'(expWrites.size()), 32'd0);
    sendFrame(8'hDE, 1'b1, 0);
    sendFrame(8'hAD, 1'b1, 0);
    sendFrame(8'hBE, 1'b1, 0);
    sendFrame(8'hEF, 1'b1, 10);
    check("address after reset", address, 32'd0);
    check("dataIn after reset", dataIn, 32'hEFBEADDE);
    check("wordCount after reset", 32'(wordCount), 32'd1);

    idle(40);
    check("writes outstanding", 32'(expWrites.size()), 32'd0);
    check("byteValid outstanding", 32'(pendingGood), 32'd0);
    check("frameErr outstanding", 32'(pendingErr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
